ctrl_fetch: RTL and testbench

// - Instruction fetch stage directly downstream of the controller PC. Reads instruction memory at the current pc.
// - Drives the PC increment/clear controls and buffers fetched words in a 2-entry skid FIFO.
// - Presents instructions to the decoder over a valid/ready handshake.
// - Stops at an end-of-program (EOP) word, then rewinds the PC to 0 and pulses done.

---
 rtl/ctrl_pkg.sv | 18 +
 rtl/ctrl_fetch_fifo.sv | 49 ++++
 rtl/ctrl_fetch.sv | 83 ++++++++
 tb/tb_ctrl_fetch.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared controller constants and fetch FSM state type
package ctrl;

  localparam int INSTRUCTION_MEMORY_SIZE = 16;
  localparam int INSTRUCTION_WIDTH       = 16;
  localparam int OPC_MSB                 = 15;
  localparam int OPC_LSB                 = 12;

  localparam logic [OPC_MSB-OPC_LSB:0] OPC_EOP = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    FLUSH
  } fetch_state_e;

endpackage

// File: rtl/ctrl_fetch_fifo.sv
// rtl/ctrl_fetch_fifo.sv - 2-entry register skid FIFO, flush wins over push/pop
module ctrl_fetch_fifo #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count == 2'd0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign do_push = push & ((count != 2'd2) | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/ctrl_fetch.sv
// rtl/ctrl_fetch.sv - instruction fetch stage: PC control, credit-based reads, EOP stop and rewind
module ctrl_fetch #(
  parameter int INSTRADDRW = $clog2(ctrl::INSTRUCTION_MEMORY_SIZE),
  parameter int INSTRW     = ctrl::INSTRUCTION_WIDTH
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  run,
  input  logic                  restart,
  input  logic [INSTRADDRW-1:0] pc,
  output logic                  pc_incr,
  output logic                  pc_clr,
  output logic                  imem_rd_en,
  output logic [INSTRADDRW-1:0] imem_addr,
  input  logic [INSTRW-1:0]     imem_rdata,
  output logic [INSTRW-1:0]     instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic                  busy,
  output logic                  done
);
  import ctrl::*;

  fetch_state_e state;
  logic         inflight;
  logic         pop;
  logic         push;
  logic         rd_eop;
  logic         issue;
  logic [1:0]   count;
  logic         empty;

  assign pop    = instr_valid & instr_ready;
  assign rd_eop = (imem_rdata[OPC_MSB:OPC_LSB] == OPC_EOP);
  // Once EOP is buffered, the single word still in flight belongs past the program end.
  assign push   = inflight & ~restart & (state != DRAIN);
  // Credit: buffered + in-flight words after this cycle's pop must leave room for one more.
  assign issue  = (state == FETCH) & run & ~restart &
                  (({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

  assign pc_incr     = issue;
  assign imem_rd_en  = issue;
  assign imem_addr   = pc;
  assign instr_valid = ~empty;
  assign done        = (state == DRAIN) & pop & ~restart & (instr[OPC_MSB:OPC_LSB] == OPC_EOP);
  assign pc_clr      = (state == FLUSH) | done;
  assign busy        = (state != IDLE) | ~empty | inflight;

  ctrl_fetch_fifo #(.W(INSTRW)) u_fifo (
    .clk   (clk),
    .clr_n (clr_n),
    .push  (push),
    .din   (imem_rdata),
    .pop   (pop),
    .flush (restart),
    .dout  (instr),
    .count (count),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= IDLE;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (restart) begin
        state <= FLUSH;
      end else begin
        case (state)
          IDLE:    if (push & rd_eop) state <= DRAIN;
                   else if (run)      state <= FETCH;
          FETCH:   if (push & rd_eop) state <= DRAIN;
                   else if (!run)     state <= IDLE;
          DRAIN:   if (done)          state <= IDLE;
          FLUSH:   state <= run ? FETCH : IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ctrl_fetch.sv
// tb/tb_ctrl_fetch.sv - self-checking bench for ctrl_fetch with PC register and memory models
module tb_ctrl_fetch;
  import ctrl::*;

  localparam int MS = INSTRUCTION_MEMORY_SIZE;
  localparam int AW = $clog2(MS);
  localparam int DW = INSTRUCTION_WIDTH;

  logic          clk = 1'b0;
  logic          clr_n, run, restart, instr_ready;
  logic [AW-1:0] pc;
  logic          pc_incr, pc_clr, imem_rd_en;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata = '0;
  logic [DW-1:0] instr;
  logic          instr_valid, busy, done;
  logic [DW-1:0] mem [MS];

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] got[$];
  logic [DW-1:0] saved[$];
  int cyc, done_cnt, clr_cnt, issued, outstanding, first_pop, last_pop;
  logic hold_prev, s_valid, s_pc_clr, s_pc_incr;
  logic [DW-1:0] hold_word;
  logic rand_ready, rand_run;

  always #5 clk = ~clk;

  ctrl_fetch dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .run         (run),
    .restart     (restart),
    .pc          (pc),
    .pc_incr     (pc_incr),
    .pc_clr      (pc_clr),
    .imem_rd_en  (imem_rd_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .busy        (busy),
    .done        (done)
  );

  // Environment: PC register sharing the reset, and a memory with one-cycle read latency.
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n)       pc <= '0;
    else if (pc_clr)  pc <= '0;
    else if (pc_incr) pc <= pc + 1'b1;
  end

  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_stats();
    got.delete();
    cyc = 0; done_cnt = 0; clr_cnt = 0; issued = 0; outstanding = 0;
    first_pop = -1; last_pop = -1; hold_prev = 1'b0;
  endtask

  task automatic fill(int eop_at);
    for (int a = 0; a < MS; a++) begin
      logic [DW-1:0] w;
      w = DW'($urandom);
      w[3:0] = 4'(a);
      w[OPC_MSB:OPC_LSB] = (a == eop_at) ? OPC_EOP : 4'($urandom_range(0, 14));
      mem[a] = w;
    end
  endtask

  // One clock: observe at the falling edge, return just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    s_valid = instr_valid; s_pc_clr = pc_clr; s_pc_incr = pc_incr;
    if (hold_prev) begin
      check("hold_valid", instr_valid, 1);
      check("hold_word", instr, hold_word);
    end
    hold_prev = instr_valid & ~instr_ready & ~restart;
    hold_word = instr;
    if (pc_incr) begin issued++; outstanding++; end
    if (instr_valid && instr_ready) begin
      got.push_back(instr);
      outstanding--;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    if (done) begin
      done_cnt++;
      check("done_on_eop_pop", {instr_valid & instr_ready, instr[OPC_MSB:OPC_LSB]}, {1'b1, OPC_EOP});
    end
    if (pc_clr) begin
      clr_cnt++;
      check("no_incr_on_clr", pc_incr, 0);
      outstanding = 0;
    end
    check("credit_le_2", outstanding <= 2, 1);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_done(int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      if (rand_ready) instr_ready = ($urandom_range(0, 3) != 0);
      if (rand_run)   run = ($urandom_range(0, 7) != 0);
      tick();
      n++;
    end
    check("done_within_budget", done_cnt != 0, 1);
    run = 1'b0;
    instr_ready = 1'b1;
    repeat (3) tick();
  endtask

  // Reference: delivered stream is memory from start address, wrapping, up to and including first EOP.
  task automatic check_stream(string tag, int start);
    logic [DW-1:0] exp[$];
    int a = start;
    for (int i = 0; i < 4 * MS; i++) begin
      exp.push_back(mem[a]);
      if (mem[a][OPC_MSB:OPC_LSB] == OPC_EOP) break;
      a = (a + 1) % MS;
    end
    check($sformatf("%s_len", tag), got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_word%0d", tag, i), got[i], exp[i]);
  endtask

  initial begin
    int n;
    int i0;
    clr_n = 1'b0; run = 1'b0; restart = 1'b0; instr_ready = 1'b0;
    rand_ready = 1'b0; rand_run = 1'b0;
    reset_stats();
    fill(3);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pc_clr", pc_clr, 0);
    check("rst_pc_incr", pc_incr, 0);
    check("rst_rd_en", imem_rd_en, 0);
    clr_n = 1'b1;
    repeat (2) tick();

    // Four-word program streamed with the decoder always ready.
    reset_stats();
    instr_ready = 1'b1; run = 1'b1;
    run_until_done(40);
    check_stream("t1", 0);
    check("t1_back_to_back", last_pop - first_pop, 3);
    check("t1_done_once", done_cnt, 1);
    check("t1_clr_once", clr_cnt, 1);
    check("t1_pc_end", pc, 0);
    check("t1_idle", busy, 0);

    // Decoder stalls for five cycles mid-stream.
    fill(9);
    reset_stats();
    instr_ready = 1'b1; run = 1'b1;
    n = 0;
    while (got.size() < 2 && n < 20) begin tick(); n++; end
    instr_ready = 1'b0;
    repeat (2) tick();
    i0 = issued;
    repeat (3) tick();
    check("t2_incr_stops", issued - i0, 0);
    check("t2_valid_held", instr_valid, 1);
    instr_ready = 1'b1;
    run_until_done(60);
    check_stream("t2", 0);
    check("t2_done_once", done_cnt, 1);

    // Restart with the buffer full.
    fill(7);
    reset_stats();
    instr_ready = 1'b0; run = 1'b1;
    repeat (6) tick();
    check("t3_pc_before", pc, 2);
    check("t3_full", instr_valid, 1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    tick();
    check("t3_flush_empty", s_valid, 0);
    check("t3_flush_clr", s_pc_clr, 1);
    check("t3_flush_no_incr", s_pc_incr, 0);
    reset_stats();
    instr_ready = 1'b1;
    run_until_done(40);
    check_stream("t3", 0);
    check("t3_done_once", done_cnt, 1);

    // Run dropped at pc = 3, then resumed.
    fill(10);
    reset_stats();
    instr_ready = 1'b1; run = 1'b1;
    n = 0;
    while (pc != 3 && n < 30) begin tick(); n++; end
    check("t4_reach_pc3", pc, 3);
    run = 1'b0;
    repeat (5) tick();
    check("t4_pc_hold", pc, 3);
    check("t4_got_len", got.size(), 3);
    check("t4_last_inflight", got[got.size()-1], mem[2]);
    run = 1'b1;
    run_until_done(60);
    check_stream("t4", 0);

    // EOP at address 1: the word read behind it must be dropped.
    fill(1);
    reset_stats();
    instr_ready = 1'b1; run = 1'b1;
    run_until_done(30);
    check_stream("t5", 0);
    check("t5_reads_issued", issued, 3);
    check("t5_done_once", done_cnt, 1);

    // Asynchronous reset in the middle of a stream.
    fill(12);
    reset_stats();
    instr_ready = 1'b1; run = 1'b1;
    repeat (5) tick();
    #2 clr_n = 1'b0;
    #1;
    check("t6_valid", instr_valid, 0);
    check("t6_instr", instr, 0);
    check("t6_incr", pc_incr, 0);
    check("t6_rd_en", imem_rd_en, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_pc_clr", pc_clr, 0);
    run = 1'b0;
    repeat (2) @(posedge clk);
    #1 clr_n = 1'b1;
    reset_stats();
    repeat (4) tick();
    check("t6_no_stale", got.size(), 0);
    check("t6_idle", busy, 0);
    run = 1'b1;
    run_until_done(60);
    check_stream("t6", 0);

    // PC wraps past the top of memory.
    fill(-1);
    reset_stats();
    instr_ready = 1'b1; run = 1'b1;
    n = 0;
    while (pc != 5 && n < 30) begin tick(); n++; end
    run = 1'b0;
    repeat (5) tick();
    check("t7_first_len", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      check($sformatf("t7_first_word%0d", i), got[i], mem[i]);
    mem[2][OPC_MSB:OPC_LSB] = OPC_EOP;
    reset_stats();
    run = 1'b1;
    run_until_done(80);
    check_stream("t7_wrap", 5);
    check("t7_pc_end", pc, 0);

    // Random programs with random decoder back-pressure and run gaps.
    for (int k = 0; k < 8; k++) begin
      fill($urandom_range(0, 13));
      reset_stats();
      rand_ready = 1'b1; rand_run = 1'b1;
      run = 1'b1;
      run_until_done(300);
      rand_ready = 1'b0; rand_run = 1'b0;
      check_stream($sformatf("rnd%0d", k), 0);
      check("rnd_done_once", done_cnt, 1);
      check("rnd_clr_once", clr_cnt, 1);
      check("rnd_pc_end", pc, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
